// File: rtl/wb_stage_if.sv
// Writeback-stage bundle: MEM-stage inputs, MDU result handshake,
// W-stage forwarding outputs and the register-file write port.
interface wb_stage_if #(
  parameter int WIDTH = 32
) ();
  logic             en_w;
  logic             flush_w;
  logic             regwrite_m;
  logic             memtoreg_m;
  logic [4:0]       writereg_m;
  logic [WIDTH-1:0] aluout_m;
  logic [WIDTH-1:0] readdata_m;
  logic             mdu_valid;
  logic [4:0]       mdu_wa;
  logic [WIDTH-1:0] mdu_wd;
  logic             mdu_ready;
  logic             regwrite_w;
  logic [4:0]       writereg_w;
  logic [WIDTH-1:0] result_w;
  logic             we3;
  logic [4:0]       wa3;
  logic [WIDTH-1:0] wd3;

  modport master (
    output en_w, flush_w, regwrite_m, memtoreg_m, writereg_m, aluout_m, readdata_m,
    output mdu_valid, mdu_wa, mdu_wd,
    input  mdu_ready, regwrite_w, writereg_w, result_w, we3, wa3, wd3
  );

  modport slave (
    input  en_w, flush_w, regwrite_m, memtoreg_m, writereg_m, aluout_m, readdata_m,
    input  mdu_valid, mdu_wa, mdu_wd,
    output mdu_ready, regwrite_w, writereg_w, result_w, we3, wa3, wd3
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB register plus register-file write-port arbitration
// between the pipeline and a small MDU result queue. WB_STATS_EN adds mdu_wait_cnt.
module wb_stage #(
  parameter int MDU_DEPTH = 2,
  parameter int WIDTH     = 32
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   wb
`ifdef WB_STATS_EN
  ,
  output logic [31:0] mdu_wait_cnt
`endif
);
  localparam int PTR_W = (MDU_DEPTH > 1) ? $clog2(MDU_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic             regwrite_p0;
  logic [4:0]       writereg_p0;
  logic [WIDTH-1:0] result_p0;

  logic [4:0]           q_wa [MDU_DEPTH];
  logic [WIDTH-1:0]     q_wd [MDU_DEPTH];
  logic [MDU_DEPTH-1:0] q_vld;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;

  logic             slot_busy;
  logic             push;
  logic             store;
  logic             found;
  logic [CNT_W-1:0] sel;
  logic [PTR_W-1:0] sel_idx;
  logic [CNT_W-1:0] pop_n;

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk) begin
    if (reset || wb.flush_w) begin
      regwrite_p0 <= 1'b0;
      writereg_p0 <= '0;
      result_p0   <= '0;
    end else if (wb.en_w) begin
      regwrite_p0 <= wb.regwrite_m;
      writereg_p0 <= wb.writereg_m;
      result_p0   <= wb.memtoreg_m ? wb.readdata_m : wb.aluout_m;
    end
  end

  assign wb.regwrite_w = regwrite_p0;
  assign wb.writereg_w = writereg_p0;
  assign wb.result_w   = result_p0;

  assign slot_busy    = regwrite_p0 && (writereg_p0 != 5'd0);
  assign wb.mdu_ready = (count != CNT_W'(MDU_DEPTH));
  assign push         = wb.mdu_valid && wb.mdu_ready;
  // r0 results complete the handshake but are never stored.
  assign store        = push && (wb.mdu_wa != 5'd0);

  // Oldest still-valid queue entry; killed entries ahead of it are skipped.
  always_comb begin
    logic [PTR_W-1:0] idx;
    found   = 1'b0;
    sel     = '0;
    sel_idx = rd_ptr;
    idx     = rd_ptr;
    for (int i = 0; i < MDU_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (!found && (CNT_W'(i) < count) && q_vld[idx]) begin
        found   = 1'b1;
        sel     = CNT_W'(i);
        sel_idx = idx;
      end
    end
  end

  always_comb begin
    wb.we3 = 1'b0;
    wb.wa3 = '0;
    wb.wd3 = '0;
    pop_n  = '0;
    if (slot_busy) begin
      wb.we3 = 1'b1;
      wb.wa3 = writereg_p0;
      wb.wd3 = result_p0;
      pop_n  = found ? sel : count;
    end else if (found) begin
      wb.we3 = 1'b1;
      wb.wa3 = q_wa[sel_idx];
      wb.wd3 = q_wd[sel_idx];
      pop_n  = sel + CNT_W'(1);
    end else begin
      pop_n  = count;
    end
  end

  // ---- MDU queue boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
    end else begin
      // Younger pipeline write to the same register supersedes queued results.
      if (slot_busy) begin
        for (int i = 0; i < MDU_DEPTH; i++) begin
          if (q_vld[i] && (q_wa[i] == writereg_p0)) q_vld[i] <= 1'b0;
        end
      end
      if (store) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count - pop_n + {{(CNT_W-1){1'b0}}, store};
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      q_wa[wr_ptr] <= wb.mdu_wa;
      q_wd[wr_ptr] <= wb.mdu_wd;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_wait_cnt <= '0;
    end else if (wb.mdu_valid && !wb.mdu_ready && (mdu_wait_cnt != 32'hFFFF_FFFF)) begin
      mdu_wait_cnt <= mdu_wait_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: MEM/WB capture, r0 suppression, MDU queue
// drain/backpressure, WAW kill and reset flush.
module tb_wb_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   r5_writes = 0;
  int   r5_bad    = 0;
  int   stale     = 0;
  logic win       = 1'b0;
`ifdef WB_STATS_EN
  logic [31:0] mdu_wait_cnt;
`endif

  wb_stage_if #(.WIDTH(32)) wb ();

  wb_stage #(.MDU_DEPTH(2), .WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
`ifdef WB_STATS_EN
    ,
    .mdu_wait_cnt (mdu_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb.we3 && wb.wa3 == 5'd5) begin
      r5_writes++;
      if (wb.wd3 != 32'h77) r5_bad++;
    end
    if (win && wb.we3) stale++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.en_w       = 1'b1;
    wb.flush_w    = 1'b0;
    wb.regwrite_m = 1'b0;
    wb.memtoreg_m = 1'b0;
    wb.writereg_m = 5'd0;
    wb.aluout_m   = 32'h0;
    wb.readdata_m = 32'h0;
    wb.mdu_valid  = 1'b0;
    wb.mdu_wa     = 5'd0;
    wb.mdu_wd     = 32'h0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] val);
    wb.regwrite_m = 1'b1;
    wb.memtoreg_m = 1'b0;
    wb.writereg_m = rd;
    wb.aluout_m   = val;
  endtask

  task automatic mdu(input logic [4:0] wa, input logic [31:0] wd);
    wb.mdu_valid = 1'b1;
    wb.mdu_wa    = wa;
    wb.mdu_wd    = wd;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_regwrite_w", wb.regwrite_w, 0);
    check("rst_writereg_w", wb.writereg_w, 0);
    check("rst_result_w", wb.result_w, 0);
    check("rst_we3", wb.we3, 0);
    check("rst_wa3", wb.wa3, 0);
    check("rst_wd3", wb.wd3, 0);
    check("rst_mdu_ready", wb.mdu_ready, 1);

    // ALU result to r8
    pipe(5'd8, 32'h1234);
    step();
    check("t1_we3", wb.we3, 1);
    check("t1_wa3", wb.wa3, 8);
    check("t1_wd3", wb.wd3, 32'h1234);
    check("t1_result_w", wb.result_w, 32'h1234);

    // load data to r0: forwarded but not written
    wb.memtoreg_m = 1'b1;
    wb.readdata_m = 32'hDEADBEEF;
    wb.writereg_m = 5'd0;
    step();
    check("t2_result_w", wb.result_w, 32'hDEADBEEF);
    check("t2_regwrite_w", wb.regwrite_w, 1);
    check("t2_we3", wb.we3, 0);

    // hold then flush
    idle();
    pipe(5'd7, 32'h70);
    step();
    wb.en_w = 1'b0;
    pipe(5'd6, 32'h60);
    step();
    check("hold_writereg_w", wb.writereg_w, 7);
    check("hold_result_w", wb.result_w, 32'h70);
    check("hold_wa3", wb.wa3, 7);
    wb.flush_w = 1'b1;
    step();
    check("flush_regwrite_w", wb.regwrite_w, 0);
    check("flush_writereg_w", wb.writereg_w, 0);
    check("flush_result_w", wb.result_w, 0);
    check("flush_we3", wb.we3, 0);

    // single MDU result with a free slot: written the cycle after acceptance
    idle();
    mdu(5'd13, 32'hD);
    step();
    wb.mdu_valid = 1'b0;
    check("lat_we3", wb.we3, 1);
    check("lat_wa3", wb.wa3, 13);
    check("lat_wd3", wb.wd3, 32'hD);
    step();
    check("lat_drained_we3", wb.we3, 0);

    // MDU result for r0 is accepted and dropped
    mdu(5'd0, 32'hEE);
    step();
    wb.mdu_valid = 1'b0;
    check("r0_mdu_ready", wb.mdu_ready, 1);
    check("r0_we3", wb.we3, 0);
    step();
    check("r0_we3_next", wb.we3, 0);

    // pipeline busy four cycles, queue fills, then drains in order
    pipe(5'd9, 32'h90);
    mdu(5'd10, 32'hA);
    step();
    check("t3_e1_wa3", wb.wa3, 9);
    check("t3_e1_ready", wb.mdu_ready, 1);
    mdu(5'd11, 32'hB);
    step();
    check("t3_e2_ready", wb.mdu_ready, 0);
    check("t3_e2_wa3", wb.wa3, 9);
    mdu(5'd12, 32'hC);
    step();
    check("t3_e3_ready", wb.mdu_ready, 0);
    step();
    check("t3_e4_ready", wb.mdu_ready, 0);
    check("t3_e4_wa3", wb.wa3, 9);
    wb.regwrite_m = 1'b0;
    wb.writereg_m = 5'd0;
    step();
    check("t3_e5_we3", wb.we3, 1);
    check("t3_e5_wa3", wb.wa3, 10);
    check("t3_e5_wd3", wb.wd3, 32'hA);
    check("t3_e5_ready", wb.mdu_ready, 0);
    step();
    check("t3_e6_wa3", wb.wa3, 11);
    check("t3_e6_wd3", wb.wd3, 32'hB);
    check("t3_e6_ready", wb.mdu_ready, 1);
    step();
    wb.mdu_valid = 1'b0;
    check("t3_e7_wa3", wb.wa3, 12);
    check("t3_e7_wd3", wb.wd3, 32'hC);
    step();
    check("t3_e8_we3", wb.we3, 0);
    check("t3_e8_ready", wb.mdu_ready, 1);

    // WAW: queued r5 superseded by pipeline r5
    idle();
    pipe(5'd9, 32'h99);
    mdu(5'd5, 32'h55);
    step();
    wb.mdu_valid = 1'b0;
    check("t4_g_wa3", wb.wa3, 9);
    pipe(5'd5, 32'h77);
    step();
    check("t4_h_wa3", wb.wa3, 5);
    check("t4_h_wd3", wb.wd3, 32'h77);
    idle();
    step();
    check("t4_i_we3", wb.we3, 0);
    step();
    check("t4_j_we3", wb.we3, 0);
    check("t4_j_ready", wb.mdu_ready, 1);

    // fill the queue behind a busy slot, wait three cycles full, then reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    pipe(5'd9, 32'h91);
    mdu(5'd20, 32'h20);
    step();
    mdu(5'd21, 32'h21);
    step();
    mdu(5'd22, 32'h22);
    step();
    step();
    step();
    check("t5_full_ready", wb.mdu_ready, 0);
`ifdef WB_STATS_EN
    check("t6_wait_cnt", mdu_wait_cnt, 3);
`endif
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_ready", wb.mdu_ready, 1);
    check("t5_rst_we3", wb.we3, 0);
    check("t5_rst_regwrite_w", wb.regwrite_w, 0);
`ifdef WB_STATS_EN
    check("t6_wait_cnt_rst", mdu_wait_cnt, 0);
`endif
    win = 1'b1;
    repeat (4) step();
    win = 1'b0;
    check("t5_stale_writes", stale, 0);

    check("t4_r5_bad_writes", r5_bad, 0);
    check("t4_r5_writes", r5_writes, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined MIPS core.
- Holds the MEM/WB pipeline register and selects the writeback result.
- Arbitrates the register file's single write port (we3/wa3/wd3, written on the falling clock edge) between the in-order pipeline and late results from the multi-cycle multiply/divide unit (MDU).
- MDU results wait in a small queue until the pipeline leaves a write slot free.

Parameters:
- MDU_DEPTH, 2, MDU result queue entries; power of two, >= 2.
- WIDTH, 32, data width of results and write data.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- en_w  in  1  MEM/WB advance enable from hazard unit; 0 = hold
- flush_w  in  1  load bubble into MEM/WB on next edge; overrides en_w
- regwrite_m  in  1  MEM-stage instruction writes a register
- memtoreg_m  in  1  1 = result is load data, 0 = ALU result
- writereg_m  in  5  MEM-stage destination register
- aluout_m  in  WIDTH  MEM-stage ALU result
- readdata_m  in  WIDTH  data memory read data
- mdu_valid  in  1  MDU offers a result
- mdu_wa  in  5  MDU destination register
- mdu_wd  in  WIDTH  MDU result
- mdu_ready  out  1  queue can accept; transfer when mdu_valid && mdu_ready
- regwrite_w  out  1  W-stage write valid (to hazard/forwarding unit)
- writereg_w  out  5  W-stage destination
- result_w  out  WIDTH  W-stage result (forwarding source)
- we3  out  1  regfile write enable
- wa3  out  5  regfile write address
- wd3  out  WIDTH  regfile write data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset state (edge with reset=1): MEM/WB cleared, regwrite_w=0, writereg_w=0, result_w=0. Queue emptied, so mdu_ready=1 in the following cycle. we3=0, wa3=0, wd3=0.
- Reset mid-operation discards queued MDU results. The MDU must reset with the core.
- MEM/WB register, at each rising edge:
  - flush_w=1: regwrite_w<=0, other fields <=0.
  - Else en_w=1: capture regwrite_m, writereg_m, and result (memtoreg_m ? readdata_m : aluout_m).
  - Else: hold.
- Pipeline slot busy = regwrite_w && writereg_w!=0.
- Write port is combinational from registered state:
  - Slot busy: we3=1, wa3=writereg_w, wd3=result_w.
  - Else queue non-empty: we3=1, wa3/wd3 = queue head; head pops at the next rising edge.
  - Else: we3=0, wa3=0, wd3=0.
- Writes to r0 are never issued: a queued entry with wa=0 is dropped on enqueue.
- Queue:
  - FIFO with MDU_DEPTH entries.
  - mdu_ready = !full, combinational from registered count.
  - Push on mdu_valid && mdu_ready. Push and pop in the same cycle are allowed; count unchanged.
  - Pointers wrap modulo MDU_DEPTH.
  - MDU latency: accept at edge N gives earliest we3 in the cycle after edge N, when the slot is free.
- WAW kill:
  - When the pipeline slot is busy, every queued entry with wa==writereg_w is invalidated; the younger pipeline write wins.
  - Invalid entries pop without asserting we3 and consume no write slot; the next valid entry may drain in the same cycle.
  - A same-cycle push with mdu_wa==writereg_w is not killed.
- Full queue: mdu_ready=0. The MDU holds mdu_wa/mdu_wd stable until accepted. The hazard unit stalls on MDU-dependent ops; this block never stalls the pipeline.

Optional Feature:
- Macro: WB_STATS_EN.
- Defined:
  - Adds output port mdu_wait_cnt [31:0], which increments each cycle mdu_valid && !mdu_ready.
  - Saturates at 0xFFFFFFFF and clears on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then regwrite_m=1, writereg_m=8, memtoreg_m=0, aluout_m=0x1234, en_w=1 for one edge -> next cycle we3=1, wa3=8, wd3=0x1234, result_w=0x1234.
2. memtoreg_m=1, readdata_m=0xDEADBEEF, writereg_m=0 -> result_w=0xDEADBEEF, regwrite_w=1, we3=0 (r0 suppressed).
3. Pipeline writes r9 on 4 consecutive cycles; MDU pushes r10=0xA, r11=0xB, then keeps mdu_valid with r12 -> mdu_ready=0 after 2 pushes. After the pipeline idles: we3 writes r10=0xA, then r11=0xB, then r12 is accepted and written.
4. Queue holds r5=0x55; pipeline writes r5=0x77 -> only 0x77 is ever written to r5; the queue entry is popped with we3=0.
5. Queue full, assert reset for one edge -> queue empty, mdu_ready=1, we3=0, no stale writes afterwards.
6. With WB_STATS_EN: 3 cycles of mdu_valid with full queue -> mdu_wait_cnt=3; after reset -> 0.
